// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// Module     : led_pattern_sequencer
// Description: Steps LED patterns (off/solid/blink/N-flash burst) on each edge
//              of the 1 Hz divider output. Option: LED_PATTERN_ABORT_EN.
// Revision   : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module led_pattern_sequencer #(
   parameter int NUM_LEDS = 4,
   parameter int BURST_W  = 4
) (
   input  logic                clk_30mhz,
   input  logic                reset,
   input  logic                tick_in,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_mode,
   input  logic [BURST_W-1:0]  cmd_count,
   output logic [NUM_LEDS-1:0] led,
   output logic                busy,
   output logic                done_pulse
);

   localparam logic [1:0] C_MODE_OFF   = 2'd0;
   localparam logic [1:0] C_MODE_SOLID = 2'd1;
   localparam logic [1:0] C_MODE_BLINK = 2'd2;
   localparam logic [1:0] C_MODE_BURST = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SOLID     = 3'd1,
      S_BLINK     = 3'd2,
      S_BURST_ON  = 3'd3,
      S_BURST_OFF = 3'd4
   } state_t;

   state_t               r_state;
   logic                 r_tick_prev;
   logic [BURST_W-1:0]   r_remaining;
   logic [NUM_LEDS-1:0]  r_led;
   logic                 r_done_pulse;
   logic                 w_step;
   logic                 w_accept;

   assign w_step   = tick_in ^ r_tick_prev;
   assign w_accept = cmd_valid && cmd_ready;

`ifdef LED_PATTERN_ABORT_EN
   assign cmd_ready = 1'b1;
`else
   assign cmd_ready = (r_state != S_BURST_ON) && (r_state != S_BURST_OFF);
`endif

   assign busy       = (r_state != S_IDLE);
   assign led        = r_led;
   assign done_pulse = r_done_pulse;

   // A command in the same cycle as a step takes priority; the step is dropped.
   always_ff @(posedge clk_30mhz or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_tick_prev  <= 1'b0;
         r_remaining  <= '0;
         r_led        <= '0;
         r_done_pulse <= 1'b0;
      end else begin
         r_tick_prev  <= tick_in;
         r_done_pulse <= 1'b0;
         if (w_accept) begin
            case (cmd_mode)
               C_MODE_OFF: begin
                  r_state <= S_IDLE;
                  r_led   <= '0;
               end
               C_MODE_SOLID: begin
                  r_state <= S_SOLID;
                  r_led   <= '1;
               end
               C_MODE_BLINK: begin
                  r_state <= S_BLINK;
                  r_led   <= '1;
               end
               C_MODE_BURST: begin
                  if (cmd_count == '0) begin
                     r_state      <= S_IDLE;
                     r_led        <= '0;
                     r_done_pulse <= 1'b1;
                  end else begin
                     r_state     <= S_BURST_ON;
                     r_led       <= '1;
                     r_remaining <= cmd_count;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_led   <= '0;
               end
            endcase
         end else if (w_step) begin
            case (r_state)
               S_BLINK: begin
                  r_led <= ~r_led;
               end
               S_BURST_ON: begin
                  r_state     <= S_BURST_OFF;
                  r_led       <= '0;
                  r_remaining <= r_remaining - 1'b1;
               end
               S_BURST_OFF: begin
                  if (r_remaining == '0) begin
                     r_state      <= S_IDLE;
                     r_done_pulse <= 1'b1;
                  end else begin
                     r_state <= S_BURST_ON;
                     r_led   <= '1;
                  end
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// Module     : tb_led_pattern_sequencer
// Description: Directed and randomized bench for led_pattern_sequencer.
// Revision   : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_led_pattern_sequencer;

   localparam int NUM_LEDS = 4;
   localparam int BURST_W  = 4;

   logic                clk_30mhz = 1'b0;
   logic                reset     = 1'b1;
   logic                tick_in   = 1'b0;
   logic                cmd_valid = 1'b0;
   logic [1:0]          cmd_mode  = 2'd0;
   logic [BURST_W-1:0]  cmd_count = '0;
   logic                cmd_ready;
   logic [NUM_LEDS-1:0] led;
   logic                busy;
   logic                done_pulse;

   led_pattern_sequencer #(.NUM_LEDS(NUM_LEDS), .BURST_W(BURST_W)) dut (
      .clk_30mhz (clk_30mhz),
      .reset     (reset),
      .tick_in   (tick_in),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_count (cmd_count),
      .led       (led),
      .busy      (busy),
      .done_pulse(done_pulse)
   );

   always #16 clk_30mhz = ~clk_30mhz;

   // Reference model: mode 0 idle, 1 solid, 2 blink, 3 burst.
   // A burst of n flashes is 2n steps; LEDs are on during even step counts.
   int m_mode;
   bit m_led;
   int m_k;
   int m_n;
   bit m_done;
   bit m_tick_prev;

   int checks = 0;
   int passed = 0;

   function automatic bit m_ready();
`ifdef LED_PATTERN_ABORT_EN
      return 1'b1;
`else
      return (m_mode != 3);
`endif
   endfunction

   task automatic model_reset();
      m_mode = 0; m_led = 1'b0; m_k = 0; m_n = 0; m_done = 1'b0; m_tick_prev = 1'b0;
   endtask

   task automatic model_edge(output bit acc);
      bit step;
      step = (tick_in != m_tick_prev);
      acc  = cmd_valid && m_ready();
      m_done = 1'b0;
      if (acc) begin
         case (cmd_mode)
            2'd0: begin m_mode = 0; m_led = 1'b0; end
            2'd1: begin m_mode = 1; m_led = 1'b1; end
            2'd2: begin m_mode = 2; m_led = 1'b1; end
            default: begin
               if (cmd_count == '0) begin
                  m_mode = 0; m_led = 1'b0; m_done = 1'b1;
               end else begin
                  m_mode = 3; m_n = int'(cmd_count); m_k = 0; m_led = 1'b1;
               end
            end
         endcase
      end else if (step) begin
         if (m_mode == 2) begin
            m_led = !m_led;
         end else if (m_mode == 3) begin
            m_k = m_k + 1;
            if (m_k == 2 * m_n) begin
               m_mode = 0; m_led = 1'b0; m_done = 1'b1;
            end else begin
               m_led = ((m_k % 2) == 0);
            end
         end
      end
      m_tick_prev = tick_in;
   endtask

   task automatic check_outputs(input string tag);
      logic [NUM_LEDS-1:0] exp_led;
      exp_led = {NUM_LEDS{m_led}};
      checks++;
      assert (led === exp_led) passed++;
      else $error("FAIL %s led=%h expected %h", tag, led, exp_led);
      checks++;
      assert (cmd_ready === m_ready()) passed++;
      else $error("FAIL %s cmd_ready=%b expected %b", tag, cmd_ready, m_ready());
      checks++;
      assert (busy === (m_mode != 0)) passed++;
      else $error("FAIL %s busy=%b expected %b", tag, busy, (m_mode != 0));
      checks++;
      assert (done_pulse === m_done) passed++;
      else $error("FAIL %s done_pulse=%b expected %b", tag, done_pulse, m_done);
   endtask

   task automatic cycle(input bit v, input logic [1:0] m, input logic [BURST_W-1:0] c,
                        input bit t, input string tag, output bit acc);
      @(negedge clk_30mhz);
      cmd_valid = v; cmd_mode = m; cmd_count = c; tick_in = t;
      @(posedge clk_30mhz);
      model_edge(acc);
      #1 check_outputs(tag);
   endtask

   task automatic idle(input int n, input string tag);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, tick_in, tag, acc);
   endtask

   task automatic toggles(input int n, input int gap, input string tag);
      bit acc;
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 2'd0, '0, !tick_in, tag, acc);
         idle(gap - 1, tag);
      end
   endtask

   // Holds the command until accepted, stepping every 10 cycles meanwhile.
   task automatic send(input logic [1:0] m, input logic [BURST_W-1:0] c, input string tag);
      bit acc;
      acc = 1'b0;
      for (int i = 0; i < 400 && !acc; i++) begin
         cycle(1'b1, m, c, ((i % 10) == 9) ? !tick_in : tick_in, tag, acc);
      end
      cycle(1'b0, 2'd0, '0, tick_in, tag, acc);
      checks++;
      assert (acc === 1'b0) passed++;
      else $error("FAIL %s_timeout accepted=%b expected 0", tag, acc);
   endtask

   task automatic async_reset_check(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs(tag);
      repeat (2) @(posedge clk_30mhz);
      #2 reset = 1'b0;
   endtask

   initial begin
      bit acc;
      model_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk_30mhz);
      #1 check_outputs("reset");
      #1 reset = 1'b0;
      idle(100, "reset_idle");

      send(2'd1, '0, "solid");
      toggles(4, 10, "solid_steps");

      send(2'd2, '0, "blink");
      toggles(4, 10, "blink_steps");

      send(2'd3, 4'd3, "burst3");
      toggles(2, 10, "burst3_steps");
      send(2'd0, '0, "off_in_burst");
      toggles(6, 10, "burst3_tail");

      send(2'd3, 4'd0, "burst0");
      idle(3, "burst0_after");

      cycle(1'b1, 2'd2, '0, !tick_in, "blink_step_same", acc);
      idle(3, "blink_step_same_after");

      send(2'd3, 4'd5, "burst5");
      toggles(3, 10, "burst5_steps");
      @(negedge clk_30mhz);
      cmd_valid = 1'b0;
      tick_in = 1'b1;
      #4 async_reset_check("reset_mid_burst");
      idle(20, "post_reset");

      for (int i = 0; i < 4000; i++) begin
         bit          v;
         logic [1:0]  m;
         logic [BURST_W-1:0] c;
         bit          t;
         v = (($urandom % 6) == 0);
         m = 2'($urandom % 4);
         c = (($urandom % 8) == 0) ? BURST_W'($urandom % 16) : BURST_W'($urandom_range(0, 4));
         t = (($urandom % 8) == 0) ? !tick_in : tick_in;
         cycle(v, m, c, t, "random", acc);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
